fighter_anim_sprite: RTL and testbench

- Parametrised successor to the single-frame fighter sprite selector.
- Selects one of NUM_POSES poses, each with FRAMES_PER_POSE animation frames. Advances frames on vertical-frame ticks and supports looping, one-shot and hold-last-frame poses, plus horizontal mirroring.
- Generates the sprite ROM address and drives a 2-cycle pixel pipeline.
- Sits between the fighter control FSM (pose_req, facing) and the VGA colour mapper.

---
 rtl/fighter_anim_sprite_if.sv | 35 +++
 rtl/fighter_anim_sprite.sv | 237 +++++++++++++++++++++++
 tb/tb_fighter_anim_sprite.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fighter_anim_sprite_if.sv
// fighter_anim_sprite_if: bundles the fighter sprite's control, pixel-coordinate,
// sprite-ROM and colour-output signals. master = surrounding system, slave = sprite block.
interface fighter_anim_sprite_if #(
    parameter int unsigned ADDR_W = 18
);
    logic              frame_start;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic [9:0]        SpriteX;
    logic [9:0]        SpriteY;
    logic [3:0]        pose_req;
    logic              facing_left;
    logic              hit_flash;
    logic              blank;
    logic [ADDR_W-1:0] rom_addr;
    logic [11:0]       rom_data;
    logic [3:0]        red;
    logic [3:0]        green;
    logic [3:0]        blue;
    logic              sprite_on;
    logic              busy;
    logic              anim_done;

    modport master (
        output frame_start, DrawX, DrawY, SpriteX, SpriteY, pose_req,
               facing_left, hit_flash, blank, rom_data,
        input  rom_addr, red, green, blue, sprite_on, busy, anim_done
    );

    modport slave (
        input  frame_start, DrawX, DrawY, SpriteX, SpriteY, pose_req,
               facing_left, hit_flash, blank, rom_data,
        output rom_addr, red, green, blue, sprite_on, busy, anim_done
    );
endinterface

// File: rtl/fighter_anim_sprite.sv
// fighter_anim_sprite: per-pose frame sequencer (loop / one-shot / hold-last)
// with horizontal mirroring, sprite-ROM addressing and a 2-cycle pixel pipeline.
// Optional feature macro: FIGHTER_HITFLASH_EN (white flashing after a hit).
module fighter_anim_sprite #(
    parameter int unsigned          NUM_POSES       = 9,
    parameter int unsigned          FRAMES_PER_POSE = 4,
    parameter int unsigned          SPRITE_W        = 64,
    parameter int unsigned          SPRITE_H        = 96,
    parameter int unsigned          HOLD_TICKS      = 6,
    parameter logic [NUM_POSES-1:0] ONESHOT_MASK    = 9'b1_1000_0110,
    parameter logic [NUM_POSES-1:0] HOLD_MASK       = 9'b0_1000_0000,
    parameter logic [11:0]          TRANSPARENT_KEY = 12'hF0F
) (
    input logic                  vga_clk,
    input logic                  Reset,
    fighter_anim_sprite_if.slave bus
);

    localparam int unsigned ADDR_W  = $clog2(NUM_POSES * FRAMES_PER_POSE * SPRITE_W * SPRITE_H);
    localparam int unsigned POSE_W  = 4;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned FRAME_W = (FRAMES_PER_POSE > 1) ? $clog2(FRAMES_PER_POSE) : 1;
    localparam int unsigned TICK_W  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [COORD_W-1:0] SPRITE_W_C = COORD_W'(SPRITE_W);
    localparam logic [COORD_W-1:0] SPRITE_H_C = COORD_W'(SPRITE_H);
    localparam logic [COORD_W-1:0] COL_MAX_C  = COORD_W'(SPRITE_W - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_POSE - 1);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(HOLD_TICKS - 1);

    localparam logic [1:0] ST_LOOP    = 2'd0;
    localparam logic [1:0] ST_ONESHOT = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    // Animation state
    logic [1:0]         state_q, state_d;
    logic [POSE_W-1:0]  pose_q, pose_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic               facing_q, facing_d;
    logic               busy_q, busy_d;
    logic               anim_done_q, anim_done_d;

    // Pixel pipeline
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               in_box_q, in_box_d;
    logic               blank_q, blank_d;
    logic               sprite_on_q, sprite_on_d;
    logic [11:0]        rgb_q, rgb_d;

    logic [POSE_W-1:0]  req_pose;
    logic               pose_change;
    logic               tick_last;
    logic               frame_last;
    logic [TICK_W-1:0]  tick_step;
    logic [FRAME_W-1:0] frame_step;

    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [COORD_W-1:0] col;
    logic               in_box;
    logic [ADDR_W-1:0]  pix_addr;
    logic               opaque;
    logic               flash_white;

    // Clamp out-of-range requests to the standing pose and precompute the tick/frame step
    always_comb begin
        req_pose    = (32'(bus.pose_req) >= NUM_POSES) ? '0 : bus.pose_req;
        pose_change = (req_pose != pose_q);
        tick_last   = (tick_q == TICK_LAST);
        frame_last  = (frame_q == FRAME_LAST);
        tick_step   = tick_last ? '0 : tick_q + 1'b1;
        frame_step  = frame_q;
        if (tick_last) begin
            frame_step = frame_last ? '0 : frame_q + 1'b1;
        end
    end

    // Animation next-state: only moves on frame_start; a pose change beats a frame advance
    always_comb begin
        state_d     = state_q;
        pose_d      = pose_q;
        frame_d     = frame_q;
        tick_d      = tick_q;
        facing_d    = facing_q;
        anim_done_d = 1'b0;
        if (bus.frame_start) begin
            facing_d = bus.facing_left;
            case (state_q)
                ST_ONESHOT: begin
                    tick_d  = tick_step;
                    frame_d = frame_step;
                    if (tick_last && frame_last) begin
                        anim_done_d = 1'b1;
                        tick_d      = '0;
                        if (HOLD_MASK[pose_q]) begin
                            state_d = ST_HOLD;
                            frame_d = frame_q;
                        end else begin
                            state_d = ST_LOOP;
                            pose_d  = '0;
                            frame_d = '0;
                        end
                    end
                end
                default: begin
                    if (pose_change) begin
                        pose_d  = req_pose;
                        frame_d = '0;
                        tick_d  = '0;
                        state_d = ONESHOT_MASK[req_pose] ? ST_ONESHOT : ST_LOOP;
                    end else if (state_q != ST_HOLD) begin
                        state_d = ST_LOOP;
                        tick_d  = tick_step;
                        frame_d = frame_step;
                    end
                end
            endcase
        end
        busy_d = (state_d == ST_ONESHOT);
    end

    // Animation registers
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state_q     <= ST_LOOP;
            pose_q      <= '0;
            frame_q     <= '0;
            tick_q      <= '0;
            facing_q    <= 1'b0;
            busy_q      <= 1'b0;
            anim_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pose_q      <= pose_d;
            frame_q     <= frame_d;
            tick_q      <= tick_d;
            facing_q    <= facing_d;
            busy_q      <= busy_d;
            anim_done_q <= anim_done_d;
        end
    end

    // Stage 0: sprite-relative coordinate, box test (no wrap past the left/top edge) and mirroring
    always_comb begin
        dx     = bus.DrawX - bus.SpriteX;
        dy     = bus.DrawY - bus.SpriteY;
        in_box = (bus.DrawX >= bus.SpriteX) && (dx < SPRITE_W_C) &&
                 (bus.DrawY >= bus.SpriteY) && (dy < SPRITE_H_C);
        col    = facing_q ? (COL_MAX_C - dx) : dx;
        pix_addr = (ADDR_W'(pose_q) * ADDR_W'(FRAMES_PER_POSE) + ADDR_W'(frame_q)) *
                   ADDR_W'(SPRITE_W * SPRITE_H) +
                   ADDR_W'(dy) * ADDR_W'(SPRITE_W) + ADDR_W'(col);
        rom_addr_d = in_box ? pix_addr : rom_addr_q;
        in_box_d   = in_box;
        blank_d    = bus.blank;
    end

    // Stage 1 registers: ROM address plus the qualifiers that travel with it
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            rom_addr_q <= '0;
            in_box_q   <= 1'b0;
            blank_q    <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            in_box_q   <= in_box_d;
            blank_q    <= blank_d;
        end
    end

`ifdef FIGHTER_HITFLASH_EN
    logic [3:0] flash_cnt_q, flash_cnt_d;
    logic       flash_par_q, flash_par_d;

    // Flash counter reloads on a hit and counts frames down; parity tracks odd frame_starts
    always_comb begin
        flash_cnt_d = flash_cnt_q;
        flash_par_d = flash_par_q;
        if (bus.hit_flash) begin
            flash_cnt_d = 4'd8;
        end else if (bus.frame_start && (flash_cnt_q != 4'd0)) begin
            flash_cnt_d = flash_cnt_q - 4'd1;
        end
        if (bus.frame_start) begin
            flash_par_d = ~flash_par_q;
        end
    end

    // Flash registers
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            flash_cnt_q <= 4'd0;
            flash_par_q <= 1'b0;
        end else begin
            flash_cnt_q <= flash_cnt_d;
            flash_par_q <= flash_par_d;
        end
    end

    assign flash_white = (flash_cnt_q != 4'd0) && flash_par_q;
`else
    logic unused_hit_flash;
    assign unused_hit_flash = bus.hit_flash;
    assign flash_white      = 1'b0;
`endif

    // Stage 2 colour: transparent key and blanking suppress the pixel
    always_comb begin
        opaque      = in_box_q && blank_q && (bus.rom_data != TRANSPARENT_KEY);
        sprite_on_d = opaque;
        rgb_d       = 12'h000;
        if (opaque) begin
            rgb_d = flash_white ? 12'hFFF : bus.rom_data;
        end
    end

    // Stage 2 registers
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            sprite_on_q <= 1'b0;
            rgb_q       <= 12'h000;
        end else begin
            sprite_on_q <= sprite_on_d;
            rgb_q       <= rgb_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.red       = rgb_q[11:8];
    assign bus.green     = rgb_q[7:4];
    assign bus.blue      = rgb_q[3:0];
    assign bus.sprite_on = sprite_on_q;
    assign bus.busy      = busy_q;
    assign bus.anim_done = anim_done_q;

endmodule

// File: tb/tb_fighter_anim_sprite.sv
// tb_fighter_anim_sprite: randomized + directed stimulus against a pulse-count
// animation model and pixel reference; expected outputs are queued per clock
// and a separate monitor compares them with what the sprite block presents.
module tb_fighter_anim_sprite;

    localparam int NP     = 9;
    localparam int F      = 4;
    localparam int SW     = 64;
    localparam int SH     = 96;
    localparam int HT     = 6;
    localparam int ADDR_W = $clog2(NP * F * SW * SH);
    localparam logic [8:0]  OS_MASK = 9'b1_1000_0110;
    localparam logic [8:0]  HD_MASK = 9'b0_1000_0000;
    localparam logic [11:0] KEY     = 12'hF0F;
`ifdef FIGHTER_HITFLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fighter_anim_sprite_if #(.ADDR_W(ADDR_W)) bus ();

    fighter_anim_sprite #(
        .NUM_POSES(NP), .FRAMES_PER_POSE(F), .SPRITE_W(SW), .SPRITE_H(SH),
        .HOLD_TICKS(HT), .ONESHOT_MASK(OS_MASK), .HOLD_MASK(HD_MASK),
        .TRANSPARENT_KEY(KEY)
    ) dut (
        .vga_clk(clk),
        .Reset  (rst),
        .bus    (bus)
    );

    // Sprite ROM stand-in: data follows the registered address within the same cycle
    logic        ovr_en;
    logic [11:0] ovr_val;

    function automatic logic [11:0] rom_fn(input logic [ADDR_W-1:0] a);
        if (a[2:0] == 3'd5) return KEY;
        return a[11:0] ^ {a[17:12], a[17:12]} ^ 12'h3C6;
    endfunction

    assign bus.rom_data = ovr_en ? ovr_val : rom_fn(bus.rom_addr);

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              busy;
        logic              done;
        logic              on;
        logic [11:0]       rgb;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus variables
    logic        s_rst, s_fs, s_face, s_hit, s_blank, s_ovr_en, rnd_face;
    logic [3:0]  s_req;
    logic [9:0]  s_drx, s_dry, s_sx, s_sy;
    logic [11:0] s_ovr;

    // Reference model: animation tracked as pulses elapsed in the current pose
    int m_pose, m_n, p_addr, fl_cnt;
    bit m_busy, m_held, m_facing, p_inbox, p_blank, fl_par;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_cycle();
        exp_t        e;
        logic [11:0] rd;
        int          dxv, dyv, col, fr, req;
        bit          inb, done, white;
        if (s_rst) begin
            e.addr = '0; e.busy = 1'b0; e.done = 1'b0; e.on = 1'b0; e.rgb = 12'h000;
            m_pose = 0; m_n = 0; m_busy = 0; m_held = 0; m_facing = 0;
            p_addr = 0; p_inbox = 0; p_blank = 0; fl_cnt = 0; fl_par = 0;
        end else begin
            white = FLASH && (fl_cnt != 0) && fl_par;
            rd    = s_ovr_en ? s_ovr : rom_fn(ADDR_W'(p_addr));
            e.on  = p_inbox && p_blank && (rd != KEY);
            e.rgb = e.on ? (white ? 12'hFFF : rd) : 12'h000;

            dxv = (int'(s_drx) - int'(s_sx)) & 1023;
            dyv = (int'(s_dry) - int'(s_sy)) & 1023;
            inb = (s_drx >= s_sx) && (dxv < SW) && (s_dry >= s_sy) && (dyv < SH);
            col = m_facing ? (SW - 1 - dxv) : dxv;
            fr  = m_held ? (F - 1) : ((m_n / HT) % F);
            if (inb) p_addr = (m_pose * F + fr) * SW * SH + dyv * SW + col;
            p_inbox = inb;
            p_blank = s_blank;
            e.addr  = ADDR_W'(p_addr);

            done = 0;
            if (s_fs) begin
                m_facing = s_face;
                req = (int'(s_req) >= NP) ? 0 : int'(s_req);
                if (m_busy) begin
                    m_n++;
                    if (m_n == F * HT) begin
                        done   = 1;
                        m_busy = 0;
                        if (HD_MASK[m_pose]) m_held = 1;
                        else begin m_pose = 0; m_n = 0; end
                    end
                end else if (req != m_pose) begin
                    m_pose = req; m_n = 0; m_held = 0; m_busy = OS_MASK[req];
                end else if (!m_held) begin
                    m_n++;
                end
            end
            e.busy = m_busy;
            e.done = done;

            if (s_hit) fl_cnt = 8;
            else if (s_fs && fl_cnt != 0) fl_cnt--;
            if (s_fs) fl_par = !fl_par;
        end
        q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        rst             = s_rst;
        bus.frame_start = s_fs;
        bus.pose_req    = s_req;
        bus.facing_left = s_face;
        bus.hit_flash   = s_hit;
        bus.blank       = s_blank;
        bus.DrawX       = s_drx;
        bus.DrawY       = s_dry;
        bus.SpriteX     = s_sx;
        bus.SpriteY     = s_sy;
        ovr_en          = s_ovr_en;
        ovr_val         = s_ovr;
        model_cycle();
    endtask

    task automatic rand_pix();
        s_sx     = 10'($urandom_range(0, 580));
        s_sy     = 10'($urandom_range(0, 400));
        s_drx    = 10'(int'(s_sx) + int'($urandom_range(0, 72)) - 4);
        s_dry    = 10'(int'(s_sy) + int'($urandom_range(0, 100)) - 2);
        s_blank  = ($urandom_range(0, 7) != 0);
        s_hit    = ($urandom_range(0, 49) == 0);
        s_ovr_en = 1'b0;
        if (rnd_face) s_face = $urandom_range(0, 1) != 0;
    endtask

    // One frame_start pulse followed by three ordinary pixel cycles
    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            s_fs = 1'b1; rand_pix(); step();
            s_fs = 1'b0;
            for (int j = 0; j < 3; j++) begin rand_pix(); step(); end
        end
    endtask

    // Monitor: pops one expectation per clock and compares every output
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("rom_addr",  32'(bus.rom_addr),  32'(e.addr));
                chk("busy",      32'(bus.busy),      32'(e.busy));
                chk("anim_done", 32'(bus.anim_done), 32'(e.done));
                chk("sprite_on", 32'(bus.sprite_on), 32'(e.on));
                chk("rgb",       32'({bus.red, bus.green, bus.blue}), 32'(e.rgb));
            end
        end
    end

    // Driver
    initial begin : driver
        s_rst = 1'b1; s_fs = 1'b0; s_req = 4'd0; s_face = 1'b0; s_hit = 1'b0;
        s_blank = 1'b0; s_drx = '0; s_dry = '0; s_sx = '0; s_sy = '0;
        s_ovr_en = 1'b0; s_ovr = 12'h000; rnd_face = 1'b1;
        step();
        s_rst = 1'b0;

        // Standing pose loops 0..3
        s_req = 4'd0; pulse(30);
        // One-shot pose 2 ignores pose_req 5 until it finishes
        s_req = 4'd2; pulse(1);
        s_req = 4'd5; pulse(30);
        // Hold pose 7 freezes on its last frame, then releases to pose 0
        s_req = 4'd7; pulse(75);
        s_req = 4'd0; pulse(3);
        // Loop pose, then an out-of-range request falls back to pose 0
        s_req = 4'd3; pulse(8);
        s_req = 4'd13; pulse(3);

        // Mirrored pixel on pose 1 frame 2
        rnd_face = 1'b0; s_face = 1'b1;
        s_req = 4'd1; pulse(13);
        s_fs = 1'b0; s_hit = 1'b0; s_sx = 10'd100; s_sy = 10'd50;
        s_drx = 10'd100; s_dry = 10'd51; s_blank = 1'b1;
        s_ovr_en = 1'b1; s_ovr = KEY;    step(); step(); step();
        s_ovr = 12'h321;                  step(); step();
        s_blank = 1'b0;                   step(); step();
        s_sx = 10'd0; s_drx = 10'd639;    step(); step();
        s_blank = 1'b1; s_sx = 10'd1000; s_drx = 10'd0; step(); step();
        s_sx = 10'd100; s_drx = 10'd163; s_dry = 10'd145; step(); step();
        s_ovr_en = 1'b0;
        rnd_face = 1'b1;

        // Reset in the middle of a one-shot
        s_req = 4'd8; pulse(5);
        s_rst = 1'b1; rand_pix(); step();
        s_rst = 1'b0; s_req = 4'd0; pulse(3);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            s_fs = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) s_req = 4'($urandom_range(0, 15));
            rand_pix();
            if ($urandom_range(0, 9) == 0) begin
                s_ovr_en = 1'b1;
                s_ovr    = ($urandom_range(0, 1) != 0) ? KEY : 12'($urandom);
            end
            s_rst = ($urandom_range(0, 1999) == 0);
            step();
        end
        s_rst = 1'b0;

        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
